yj_fifo_rd_stream: RTL and testbench
====================================

YJ_FIFO_RD_STREAM -- requirements
Module: yj_fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the data word width in bits.
REQ-002 The block SHALL have parameter CW, default 16, giving the pop counter width in bits.
REQ-003 CLK  input  1  The single clock; all state is updated on its rising edge.
REQ-004 RST  input  1  Reset, synchronous and active-high.
REQ-005 fifo_empty  input  1  Empty flag from the asynchronous FIFO read side.
REQ-006 fifo_rd_en  output  1  Pop request to the FIFO; one word is popped per asserted cycle.
REQ-007 fifo_rd_data  input  DW  FIFO read data, valid on the cycle after fifo_rd_en is asserted.
REQ-008 m_valid  output  1  Downstream word available.
REQ-009 m_ready  input  1  Downstream accept.
REQ-010 m_data  output  DW  Downstream word, stable while m_valid=1 and m_ready=0.
REQ-011 pop_cnt  output  CW  Saturating count of words delivered downstream.

Function
REQ-012 The block SHALL hold a 2-entry in-order output buffer whose state is EMPTY, ONE or TWO.
- m_valid = (state != EMPTY).
- m_data = head entry.
REQ-013 A register inflight SHALL equal fifo_rd_en delayed by one cycle.
- When inflight=1, fifo_rd_data is written into the buffer in that cycle.
REQ-014 Define pop = m_valid & m_ready; occupancy occ = 0/1/2 for EMPTY/ONE/TWO.
REQ-015 fifo_rd_en SHALL equal !RST & !fifo_empty & ((occ + inflight - pop) < 2).
- This is a combinational path from m_ready; it never over-commits the buffer.
REQ-016 State transitions (arr = inflight):
- EMPTY: arr -> ONE; otherwise stay.
- ONE: arr & !pop -> TWO; !arr & pop -> EMPTY; otherwise stay.
- TWO: pop & !arr -> ONE; pop & arr -> TWO; !pop -> TWO.
REQ-017 arr=1 in TWO with pop=0 SHALL never occur; a bench assertion flags it.
REQ-018 Simultaneous arr and pop SHALL pop the head and append the new word at the tail, in FIFO order.
REQ-019 Arrival into EMPTY SHALL set m_valid=1 on the next cycle, giving 2 cycles from fifo_rd_en to m_valid.
REQ-020 With fifo_empty=0 and m_ready held at 1, throughput SHALL be one word per cycle once the pipeline is primed.
REQ-021 While m_valid=1 and m_ready=0, m_data SHALL NOT change.
REQ-022 pop_cnt SHALL increment by 1 on each pop and saturate at 2^CW-1 without wrapping.
REQ-023 fifo_empty asserting SHALL only deassert fifo_rd_en; a word already in flight SHALL still be captured.

Reset
REQ-024 While RST=1 at a clock edge, the following SHALL be cleared on that edge:
- state = EMPTY, inflight = 0, both buffer entries = 0, pop_cnt = 0.
- Outputs after that edge: m_valid = 0, m_data = 0, fifo_rd_en = 0.
REQ-025 Reset mid-operation SHALL discard buffered and in-flight words.
- fifo_rd_data arriving on the cycle after RST falls SHALL be ignored, because inflight is 0.

Structure
REQ-026 State encodings SHALL be constants in the shared yj_fifo_pkg include: EMPTY=2'b00, ONE=2'b01, TWO=2'b10.
REQ-027 The 2-entry buffer plus state machine SHALL be one sub-module, yj_skid_buf2, parameterised by DW.
- The top level holds the credit logic, the inflight register and pop_cnt.

Verification
REQ-028 Basic transfer:
- Stimulus: reset, then FIFO holding 0x11, 0x22, 0x33, with m_ready=1.
- Response: fifo_rd_en high 3 cycles; m_data 0x11/0x22/0x33 on consecutive cycles starting 2 cycles after the first fifo_rd_en; pop_cnt=3.
REQ-029 Backpressure:
- Stimulus: m_ready=0 with 5 words available.
- Response: exactly 2 pops issued; state=TWO; m_data=first word, held stable; after m_ready=1, all 5 words delivered in order with no loss.
REQ-030 Simultaneous arrive/pop in TWO:
- Stimulus: m_ready toggles 1,0,1,0 with a continuous supply.
- Response: order preserved; the no-overflow assertion never fires.
REQ-031 Reset mid-flight:
- Stimulus: RST asserted the cycle after fifo_rd_en with the buffer in ONE.
- Response: m_valid=0, pop_cnt=0 next cycle; the late fifo_rd_data 0xDEAD is never output.
REQ-032 Saturation:
- Stimulus: CW=4, 20 pops.
- Response: pop_cnt stops at 15.
REQ-033 Empty edge:
- Stimulus: fifo_empty rises the same cycle fifo_rd_en is high.
- Response: the in-flight word is still delivered, then fifo_rd_en stays 0.

Source files
------------

// File: rtl/yj_fifo_pkg.sv
// Shared constants for the FIFO read-stream block: output buffer state
// encodings and an occupancy helper.
package yj_fifo_pkg;

   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] ONE   = 2'b01;
   localparam logic [1:0] TWO   = 2'b10;

   // Number of words held by the output buffer in a given state.
   function automatic logic [1:0] occ_of(input logic [1:0] st);
      case (st)
         ONE:     return 2'd1;
         TWO:     return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/yj_skid_buf2.sv
// Two-entry in-order output buffer. Entry 0 is always the head; a new word
// lands behind whatever is still held.
module yj_skid_buf2
   import yj_fifo_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          pop,
   output logic [1:0]    state,
   output logic [DW-1:0] head
);

   logic [DW-1:0] ent0;
   logic [DW-1:0] ent1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would make ent0 <= ent1 order-dependent.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= EMPTY;
         // NOTE: the two data entries are reset because m_data must read 0 after
         // reset; a deeper storage array would normally be left unreset.
         ent0  <= '0;
         ent1  <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (wr_en) begin
                  ent0  <= wr_data;
                  state <= ONE;
               end
            end
            ONE: begin
               if (wr_en && pop) begin
                  ent0 <= wr_data;
               end else if (wr_en) begin
                  ent1  <= wr_data;
                  state <= TWO;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               // The credit logic never launches a word into a full buffer
               // unless that same cycle frees a slot.
               if (pop) begin
                  ent0 <= ent1;
                  if (wr_en) ent1 <= wr_data;
                  else       state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign head = ent0;

endmodule

// File: rtl/yj_fifo_rd_stream.sv
// Streams words out of an asynchronous FIFO read port into a valid/ready
// interface, using one-cycle read latency credit accounting.
module yj_fifo_rd_stream
   import yj_fifo_pkg::*;
#(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          fifo_empty,
   output logic          fifo_rd_en,
   input  logic [DW-1:0] fifo_rd_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [CW-1:0] pop_cnt
);

   logic [1:0] state;
   logic       inflight;
   logic       pop;
   logic [2:0] committed;

   yj_skid_buf2 #(.DW(DW)) u_buf (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (inflight),
      .wr_data (fifo_rd_data),
      .pop     (pop),
      .state   (state),
      .head    (m_data)
   );

   assign m_valid = (state != EMPTY);
   assign pop     = m_valid & m_ready;

   // Words held plus the word on its way, minus the one leaving now; pop
   // implies at least one held word, so this never underflows.
   assign committed  = {1'b0, occ_of(state)} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = !RST && !fifo_empty && (committed < 3'd2);

   always_ff @(posedge CLK) begin
      if (RST) begin
         inflight <= 1'b0;
         pop_cnt  <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (pop && (pop_cnt != {CW{1'b1}})) pop_cnt <= pop_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_yj_fifo_rd_stream.sv
// Self-checking bench: a queue-based model of the read stream checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_yj_fifo_rd_stream;

   localparam int DW = 32;
   localparam logic [DW-1:0] LATE = 32'h0000_DEAD;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_rd_data = LATE;
   logic          m_ready = 1'b0;

   logic          fifo_rd_en, fifo_rd_en_s;
   logic          m_valid, m_valid_s;
   logic [DW-1:0] m_data, m_data_s;
   logic [15:0]   pop_cnt;
   logic [3:0]    pop_cnt_s;

   always #5 CLK = ~CLK;

   yj_fifo_rd_stream #(.DW(DW), .CW(16)) dut (
      .CLK (CLK), .RST (RST), .fifo_empty (fifo_empty), .fifo_rd_en (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data), .m_valid (m_valid), .m_ready (m_ready),
      .m_data (m_data), .pop_cnt (pop_cnt)
   );

   yj_fifo_rd_stream #(.DW(DW), .CW(4)) dut_s (
      .CLK (CLK), .RST (RST), .fifo_empty (fifo_empty), .fifo_rd_en (fifo_rd_en_s),
      .fifo_rd_data (fifo_rd_data), .m_valid (m_valid_s), .m_ready (m_ready),
      .m_data (m_data_s), .pop_cnt (pop_cnt_s)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] src_q[$];
   logic [DW-1:0] out_q[$];
   logic [DW-1:0] del_q[$];
   int            del_cyc[$];
   logic          m_infl = 1'b0;
   int            m_cnt = 0;
   bit            known = 1'b0;
   bit            head_zero = 1'b0;
   int            rd_cnt, cyc, first_rd, first_val;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model of one clock: compare outputs, then advance the model across the edge.
   task automatic model_cycle();
      int   occ;
      logic exp_valid, exp_pop, exp_rd;
      occ       = out_q.size();
      exp_valid = (occ > 0);
      exp_pop   = exp_valid && m_ready;
      exp_rd    = !RST && !fifo_empty && ((occ + int'(m_infl) - int'(exp_pop)) < 2);
      if (known) begin
         check("rd_en", fifo_rd_en, exp_rd);
         check("m_valid", m_valid, exp_valid);
         if (exp_valid) check("m_data", m_data, out_q[0]);
         else if (head_zero) check("m_data_reset", m_data, 0);
         check("pop_cnt", pop_cnt, m_cnt);
         check("rd_en_cw4", fifo_rd_en_s, exp_rd);
         check("m_valid_cw4", m_valid_s, exp_valid);
         if (exp_valid) check("m_data_cw4", m_data_s, out_q[0]);
         check("pop_cnt_cw4", pop_cnt_s, (m_cnt > 15) ? 15 : m_cnt);
         check("no_overflow", (m_infl && occ == 2 && !exp_pop), 0);
      end
      if (fifo_rd_en) begin
         rd_cnt++;
         if (first_rd < 0) first_rd = cyc;
      end
      if (exp_valid && first_val < 0) first_val = cyc;
      if (RST) begin
         out_q.delete();
         m_infl    = 1'b0;
         m_cnt     = 0;
         known     = 1'b1;
         head_zero = 1'b1;
      end else begin
         if (exp_pop) begin
            del_q.push_back(out_q.pop_front());
            del_cyc.push_back(cyc);
            if (m_cnt < 65535) m_cnt++;
         end
         if (m_infl) begin
            if (out_q.size() < 2) out_q.push_back(fifo_rd_data);
            head_zero = 1'b0;
         end
         m_infl = exp_rd;
      end
      cyc++;
   endtask

   // Inputs change just after the rising edge; outputs are compared at the falling edge.
   task automatic step(input logic rst_i, input logic rdy_i);
      logic rd_now;
      RST        = rst_i;
      m_ready    = rdy_i;
      fifo_empty = (src_q.size() == 0);
      @(negedge CLK);
      model_cycle();
      rd_now = fifo_rd_en;
      @(posedge CLK);
      #1;
      if (rd_now && src_q.size() > 0) fifo_rd_data = src_q.pop_front();
      else                            fifo_rd_data = LATE;
   endtask

   task automatic new_phase();
      del_q.delete();
      del_cyc.delete();
      rd_cnt    = 0;
      cyc       = 0;
      first_rd  = -1;
      first_val = -1;
   endtask

   task automatic do_reset();
      src_q.delete();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      new_phase();
   endtask

   initial begin
      new_phase();
      do_reset();
      check("reset_m_valid", m_valid, 0);
      check("reset_m_data", m_data, 0);
      check("reset_pop_cnt", pop_cnt, 0);

      // Basic transfer.
      src_q = '{32'h11, 32'h22, 32'h33};
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      check("basic_rd_cycles", rd_cnt, 3);
      check("basic_latency", first_val - first_rd, 2);
      check("basic_count", del_q.size(), 3);
      if (del_q.size() == 3) begin
         check("basic_w0", del_q[0], 32'h11);
         check("basic_w1", del_q[1], 32'h22);
         check("basic_w2", del_q[2], 32'h33);
         check("basic_back_to_back", del_cyc[2] - del_cyc[0], 2);
      end
      check("basic_pop_cnt", pop_cnt, 3);

      // Backpressure.
      do_reset();
      src_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
      check("bp_rd_cycles", rd_cnt, 2);
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data", m_data, 32'hA1);
      check("bp_state_two", dut.u_buf.state, yj_fifo_pkg::TWO);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
      check("bp_count", del_q.size(), 5);
      for (int i = 0; i < del_q.size(); i++) check("bp_order", del_q[i], 32'hA1 + i);
      check("bp_pop_cnt", pop_cnt, 5);

      // Alternating ready with continuous supply.
      do_reset();
      for (int i = 0; i < 12; i++) src_q.push_back(32'hB00 + i);
      for (int i = 0; i < 24; i++) step(1'b0, (i % 2) == 0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      check("alt_count", del_q.size(), 12);
      for (int i = 0; i < del_q.size(); i++) check("alt_order", del_q[i], 32'hB00 + i);

      // Reset while a word is in flight and one is buffered.
      do_reset();
      src_q = '{32'hC0};
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      check("rst_pre_pop_cnt", pop_cnt, 1);
      src_q = '{32'hC1, LATE};
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("rst_pre_state_one", dut.u_buf.state, yj_fifo_pkg::ONE);
      step(1'b1, 1'b0);
      check("rst_mid_m_valid", m_valid, 0);
      check("rst_mid_pop_cnt", pop_cnt, 0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
      check("rst_mid_delivered", del_q.size(), 1);
      if (del_q.size() > 0) check("rst_mid_w0", del_q[0], 32'hC0);

      // Counter saturation on the CW=4 instance.
      do_reset();
      for (int i = 0; i < 20; i++) src_q.push_back(32'hD00 + i);
      for (int i = 0; i < 26; i++) step(1'b0, 1'b1);
      check("sat_count", del_q.size(), 20);
      check("sat_pop_cnt_cw4", pop_cnt_s, 15);
      check("sat_pop_cnt_cw16", pop_cnt, 20);

      // FIFO runs empty while the last word is still in flight.
      do_reset();
      src_q = '{32'h71, 32'h72};
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      check("empty_rd_cycles", rd_cnt, 2);
      check("empty_count", del_q.size(), 2);
      if (del_q.size() == 2) begin
         check("empty_w0", del_q[0], 32'h71);
         check("empty_w1", del_q[1], 32'h72);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
